// File: rtl/alu_result_disp.sv
// ---------------------------------------------------------------------------
// alu_result_disp
//
// Display back-end for the 4-bit ALU board. The ALU result and flags are
// sampled once per SAMPLE_DIV clock cycles into holding registers, so the
// display stays stable while switches bounce. The held result is decoded into
// three active-low seven-segment digits (sign, tens, ones) and three flag
// LEDs.
//
// Parameters:
//   NBIT        ALU result width, 2..6 (magnitude fits in two decimal digits)
//   SAMPLE_DIV  clock cycles per sample period, >= 2
//   BLINK_DIV   clock cycles per overflow-blink half period, >= 2
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   result       in   [NBIT-1:0] ALU result
//   overflow     in   ALU overflow flag
//   zero         in   ALU zero flag
//   carry        in   ALU carry flag
//   disp_signed  in   1: show result as two's complement, 0: unsigned
//   freeze       in   1: suppress new samples, hold the current display
//   seg2         out  [6:0] sign digit, active-low, {g,f,e,d,c,b,a}
//   seg1         out  [6:0] tens digit
//   seg0         out  [6:0] ones digit
//   led_flags    out  [2:0] {overflow, zero, carry}, active-high
//   sample_pulse out  one-cycle strobe when new display values first appear
//
// Build option:
//   ALU_DISP_BLINK_EN  when defined, the overflow LED blinks with a half
//                      period of BLINK_DIV cycles instead of being steady.
//
// Handshake: none. Inputs are level signals sampled only at the capture edge
// (terminal divider count with freeze low); sample_pulse is a plain strobe
// with no back-pressure.
// ---------------------------------------------------------------------------
module alu_result_disp #(
    parameter int NBIT       = 4,
    parameter int SAMPLE_DIV = 500000,
    parameter int BLINK_DIV  = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBIT-1:0] result,
    input  logic            overflow,
    input  logic            zero,
    input  logic            carry,
    input  logic            disp_signed,
    input  logic            freeze,
    output logic [6:0]      seg2,
    output logic [6:0]      seg1,
    output logic [6:0]      seg0,
    output logic [2:0]      led_flags,
    output logic            sample_pulse
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (NBIT < 2 || NBIT > 6) begin : g_bad_nbit
        $error("alu_result_disp: NBIT must be in 2..6");
    end
    if (SAMPLE_DIV < 2) begin : g_bad_sample_div
        $error("alu_result_disp: SAMPLE_DIV must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("alu_result_disp: BLINK_DIV must be >= 2");
    end

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low digit patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // Sample divider and capture strobe
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             div_tc;
    logic             capture;

    always_comb begin
        div_tc  = (div_q == DIV_W'(SAMPLE_DIV - 1));
        // The divider keeps running while frozen; freeze only masks capture.
        capture = div_tc & ~freeze;
        div_d   = div_tc ? '0 : div_q + DIV_W'(1);
    end

    // -----------------------------------------------------------------------
    // Holding registers
    // -----------------------------------------------------------------------
    logic [NBIT-1:0] res_q,  res_d;
    logic            ovf_q,  ovf_d;
    logic            zero_q, zero_d;
    logic            car_q,  car_d;
    logic            sgn_q,  sgn_d;
    // Marks the cycle after a capture, so the pulse lines up with the
    // first cycle the new display values are visible.
    logic            cap_q,  cap_d;

    always_comb begin
        res_d  = res_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        car_d  = car_q;
        sgn_d  = sgn_q;
        cap_d  = capture;
        if (capture) begin
            res_d  = result;
            ovf_d  = overflow;
            zero_d = zero;
            car_d  = carry;
            sgn_d  = disp_signed;
        end
    end

    // -----------------------------------------------------------------------
    // Decode of the held result (never of the live inputs)
    // -----------------------------------------------------------------------
    logic            neg;
    logic [NBIT:0]   mag;
    logic [7:0]      mag8;
    logic [3:0]      tens;
    logic [3:0]      ones;
    logic [6:0]      seg2_d, seg1_d, seg0_d;

    always_comb begin
        neg = sgn_q & res_q[NBIT-1];
        // One extra bit keeps the most negative value exact:
        // e.g. 4'b1000 -> 0_0111 + 1 = 8.
        if (neg) begin
            mag = {1'b0, ~res_q} + (NBIT+1)'(1);
        end else begin
            mag = {1'b0, res_q};
        end
        // Divide in 8 bits so the constant 10 is representable for any NBIT.
        mag8 = 8'(mag);
        tens = 4'(mag8 / 8'd10);
        ones = 4'(mag8 % 8'd10);

        seg2_d = neg ? SEG_MINUS : SEG_BLANK;
        seg1_d = (tens == 4'd0) ? SEG_BLANK : seg_digit(tens);
        seg0_d = seg_digit(ones);
    end

    // -----------------------------------------------------------------------
    // Overflow LED drive
    // -----------------------------------------------------------------------
    logic       ovf_led;
    logic [2:0] led_d;

`ifdef ALU_DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic               blink_tc;

    // Free-running; a capture does not restart the blink.
    always_comb begin
        blink_tc = (blink_q == BLINK_W'(BLINK_DIV - 1));
        blink_d  = blink_tc ? '0 : blink_q + BLINK_W'(1);
        phase_d  = blink_tc ? ~phase_q : phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            phase_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    assign ovf_led = ovf_q & phase_q;
`else
    assign ovf_led = ovf_q;
`endif

    assign led_d = {ovf_led, zero_q, car_q};

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    logic [6:0] seg2_q, seg1_q, seg0_q;
    logic [2:0] led_q;
    logic       pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            car_q   <= 1'b0;
            sgn_q   <= 1'b0;
            cap_q   <= 1'b0;
            seg2_q  <= SEG_BLANK;
            seg1_q  <= SEG_BLANK;
            seg0_q  <= SEG_ZERO;
            led_q   <= 3'b000;
            pulse_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            car_q   <= car_d;
            sgn_q   <= sgn_d;
            cap_q   <= cap_d;
            // Display registers follow the held values every cycle; since the
            // held values only move at a capture, the display changes exactly
            // one cycle after it.
            seg2_q  <= seg2_d;
            seg1_q  <= seg1_d;
            seg0_q  <= seg0_d;
            led_q   <= led_d;
            pulse_q <= cap_q;
        end
    end

    assign seg2         = seg2_q;
    assign seg1         = seg1_q;
    assign seg0         = seg0_q;
    assign led_flags    = led_q;
    assign sample_pulse = pulse_q;

endmodule

// File: doc/alu_result_disp.md
# alu_result_disp

Display back-end for the 4-bit ALU board top: consumes the ALU's result and flags, samples them at a fixed rate into holding registers, and drives three active-low seven-segment digits (sign, tens, ones) and three flag LEDs. It sits directly downstream of the ALU and replaces the raw LED result wiring. The display stays stable and readable while switches bounce.

## Interface
Parameters:
- NBIT, 4, ALU result width; legal range 2..6, so the magnitude is at most 63 and fits in two decimal digits.
- SAMPLE_DIV, 500000, clock cycles per sample period; minimum 2.
- BLINK_DIV, 5000000, clock cycles per overflow-blink half period; minimum 2.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- result  in  NBIT  ALU result.
- overflow  in  1  ALU overflow flag.
- zero  in  1  ALU zero flag.
- carry  in  1  ALU carry flag.
- disp_signed  in  1  1 means show the result as two's complement; 0 means unsigned.
- freeze  in  1  1 means hold the current display and suppress new samples.
- seg2  out  7  sign digit, active-low, bit order {g,f,e,d,c,b,a}.
- seg1  out  7  tens digit.
- seg0  out  7  ones digit.
- led_flags  out  3  {overflow, zero, carry}, active-high.
- sample_pulse  out  1  one-cycle strobe when new display values first appear.

## Operation
- div_cnt counts 0..SAMPLE_DIV-1 and wraps. It runs continuously, regardless of freeze.
- Capture edge: the rising edge where div_cnt==SAMPLE_DIV-1 and freeze==0.
  - At this edge, res_q, ovf_q, zero_q, car_q and sgn_q (disp_signed) load from the inputs.
  - If freeze==1 at the terminal count, no capture occurs, no pulse follows, and the divider still wraps.
- Decode, from the captured registers only:
  - Negative when sgn_q==1 and res_q[NBIT-1]==1; magnitude = (~res_q)+1, computed in NBIT+1 bits so that -2^(NBIT-1) is exact (for example, -8 shows as 8).
  - Otherwise, magnitude = res_q, zero-extended.
  - tens = mag/10, ones = mag%10.
  - seg2 = '-' (0111111) if negative, else blank (1111111).
  - seg1 = blank if tens==0, else the digit pattern.
  - seg0 always shows a digit.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Flag LEDs: led_flags[1]=zero_q, led_flags[0]=car_q, led_flags[2] is the overflow drive described under Configuration.

## Timing
- seg0/1/2 and led_flags are registered. They reflect the values captured at edge T from edge T+1 onward.
- sample_pulse is high for exactly the cycle between edges T+1 and T+2.
- Latency from the input change to the display is at most SAMPLE_DIV+1 cycles.
- Inputs are sampled only at the capture edge. Changes between captures are ignored, including changes to disp_signed.
- Reset values, held asynchronously while rst=1:
  - div_cnt=0, blink_cnt=0, blink_phase=1, all captured registers 0.
  - seg2=1111111, seg1=1111111, seg0=1000000 ("0").
  - led_flags=000, sample_pulse=0.
- Reset mid-period clears the divider. The first capture is then the edge SAMPLE_DIV cycles after rst deasserts.
- If freeze deasserts at the terminal-count cycle itself, that edge captures.

## Configuration
- ALU_DISP_BLINK_EN defined:
  - blink_cnt counts 0..BLINK_DIV-1, and blink_phase toggles at each wrap.
  - led_flags[2] = ovf_q & blink_phase, registered.
  - blink_cnt is free-running and is not reset by a capture.
- ALU_DISP_BLINK_EN undefined:
  - No blink counter is built.
  - led_flags[2] = ovf_q, steady.

## Test plan
Run all scenarios with SAMPLE_DIV=4 and BLINK_DIV=3.
1. Reset, then run 3 cycles → seg2=1111111, seg1=1111111, seg0=1000000, led_flags=000, sample_pulse=0.
2. Unsigned capture: result=4'hD, disp_signed=0, carry=1 held through a capture → next cycle seg1=1111001, seg0=0110000, seg2 blank, led_flags=001, sample_pulse high for 1 cycle.
3. Signed minimum: result=4'h8, disp_signed=1, overflow=1 → seg2=0111111, seg1 blank, seg0=0000000. With the macro, led_flags[2] toggles every 3 cycles; without it, led_flags[2] is steady 1.
4. Freeze: freeze=1, then result changes from 5 to 7 across two sample periods → display stays "5" and no sample_pulse. Release freeze → "7" (1111000) appears at the next terminal count+1.
5. Reset mid-operation: assert rst while showing "-3" → outputs return to reset values immediately, and the first capture follows 4 cycles after rst deasserts.
6. Zero flag with signed 0: result=0, zero=1, disp_signed=1 → seg2 blank, seg0=1000000, led_flags=010.
